// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts one cache line read/write into a multi-beat burst
// on the memory side and returns a single-cycle completion pulse.
`default_nettype none

module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = $clog2(num_beats);
  localparam logic [cnt_w-1:0] last_cnt  = cnt_w'(num_beats - 1);
  localparam logic [31:0]      line_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [cnt_w-1:0]  cnt;
  logic [s_line-1:0] rd_buf;
  logic [s_line-1:0] wr_buf;
  logic              beat;
  logic              last_beat;
  logic              accept;

  assign beat      = resp_i && ((state == RD) || (state == WR));
  assign last_beat = beat && (cnt == last_cnt);
  assign accept    = (state == IDLE) && (read_i || write_i);

  // Read and write lines live in separate buffers so a writeback never
  // disturbs the line last returned to the cache.
  assign line_o  = rd_buf;
  assign burst_o = wr_buf[cnt*s_burst +: s_burst];

  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    case (state)
      IDLE: begin
        if (write_i)     state_next = WR;
        else if (read_i) state_next = RD;
      end
      RD: begin
        read_o = 1'b1;
        if (last_beat) state_next = DONE;
      end
      WR: begin
        write_o = 1'b1;
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      address_o <= '0;
      rd_buf    <= '0;
      wr_buf    <= '0;
    end else if (accept) begin
      cnt       <= '0;
      address_o <= address_i & line_mask;
      if (write_i) wr_buf <= line_i;
    end else if (beat) begin
      cnt <= cnt + cnt_w'(1);
      if (state == RD) rd_buf[cnt*s_burst +: s_burst] <= burst_i;
    end
  end

endmodule

`default_nettype wire

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Memory-side responder for the cache's physical-memory port. Accepts one 256-bit line read or write from the cache (`pmem_*` side) and converts it into a 4-beat, 64-bit burst transaction on the DRAM/arbiter interface. Returns an assembled line on reads and a single-cycle completion pulse on both reads and writes. Sits between `cache_datapath`/cache control and the burst memory model.

## Interface
Parameters:
- `s_offset`, 5: line offset bits; burst address is line-aligned (low `s_offset` bits zero).
- `s_line`, 256: line width in bits.
- `s_burst`, 64: beat width in bits. `num_beats = s_line / s_burst` = 4. Beat counter width is `$clog2(num_beats)`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `line_i`  in  256  write line from cache (`pmem_wdata`).
- `line_o`  out  256  read line to cache (`pmem_rdata`).
- `address_i`  in  32  line address from cache (`pmem_address`).
- `read_i`  in  1  line read request, held until `resp_o`.
- `write_i`  in  1  line write request, held until `resp_o`.
- `resp_o`  out  1  one-cycle completion pulse.
- `burst_i`  in  64  read beat data from memory.
- `burst_o`  out  64  write beat data to memory.
- `address_o`  out  32  burst address, `{address_i[31:s_offset], s_offset'b0}` latched.
- `read_o`  out  1  burst read request.
- `write_o`  out  1  burst write request.
- `resp_i`  in  1  per-beat acknowledge from memory.

## Operation
- FSM states: IDLE, RD, WR, DONE. Reset → IDLE.
- IDLE: if `write_i`, latch `line_i` and aligned address, clear beat count → WR. Else if `read_i`, latch address, clear count → RD. `write_i` wins if both are high; the cache never issues both.
- RD: `read_o`=1. On each `resp_i`, store `burst_i` into line-buffer slice `[cnt*64 +: 64]` and increment `cnt`. On the beat with `cnt==3` → DONE.
- WR: `write_o`=1, `burst_o` = latched line slice `[cnt*64 +: 64]`. On each `resp_i`, increment `cnt`. On the beat with `cnt==3` → DONE.
- DONE: `resp_o`=1 for exactly one cycle → IDLE. `read_o` and `write_o` are 0.
- Beat order is ascending: beat 0 = bits 63:0, beat 3 = bits 255:192.
- `line_o` is driven from the line buffer. It is stable from DONE until the next RD captures beat 0. WR never modifies the buffer seen on `line_o`; use separate read and write buffers, or keep the read buffer untouched.
- `resp_i` in IDLE or DONE is ignored.
- `address_i`/`line_i` changes after acceptance do not affect the in-flight burst.
- Beat gaps are allowed: `resp_i` may drop between beats. The FSM holds `cnt` and stays in RD/WR with request asserted.

## Timing
- Reset (async assert, any state): state=IDLE, `cnt`=0, `resp_o`=0, `read_o`=0, `write_o`=0, `address_o`=0, `burst_o`=0, `line_o`=0. Takes effect without a clock edge.
- Reset mid-burst aborts the transaction. No completion pulse is issued. The memory model must be reset alongside.
- Request sampled in IDLE at edge N → `read_o`/`write_o` high from N+1.
- Last `resp_i` at edge M → `read_o`/`write_o` low and `resp_o` high during cycle M+1 → IDLE at M+2.
- Back-to-back: a request still high in the first IDLE cycle after DONE is treated as new. The cache drops its request the cycle after `resp_o`, so no spurious repeat occurs.
- Minimum latency, memory acknowledging every cycle starting immediately: 6 cycles from request to `resp_o` (1 accept + 4 beats + 1 DONE).

## Test plan
- Reset: assert `rst`=0 asynchronously mid-cycle → all outputs 0 immediately. Release, idle 5 cycles → no `read_o`/`write_o`/`resp_o`.
- Read: `read_i`, `address_i`=0x1234_567F; memory returns beats 0x0..0x3 (`64'hA0`..`64'hA3`) on 4 consecutive `resp_i` → `address_o`=0x1234_5660, `read_o` held 4 cycles, `resp_o` single pulse, `line_o`={A3,A2,A1,A0}.
- Write: `write_i`, `line_i`={D,C,B,A} (64-bit each), `resp_i` with 2-cycle gaps between beats → `burst_o` shows A,B,C,D in order, each held until its `resp_i`. `resp_o` pulses once. `line_o` unchanged from the prior read.
- Priority/ignore: `read_i`=`write_i`=1 → write burst issued. `resp_i` pulsed in IDLE → no state change.
- Reset mid-read after 2 beats, then new read of 0x0000_0040 → fresh 4-beat burst, correct line, no stale beats.
- Back-to-back writeback then fill: write to 0x8000_0020 then read to 0x9000_0020, cache dropping each request the cycle after `resp_o` → exactly two `resp_o` pulses and two bursts with correct addresses.
